// File: rtl/neural_io_pkg.sv
// Shared types and constants for the DE2 neural operand I/O path.
// The key indices match the physical KEY[3:0] push-buttons.
package neural_io_pkg;

  localparam int OPERAND_W = 32;
  localparam int HALF_W    = 16;

  localparam int KEY_LOAD_LO = 0;
  localparam int KEY_LOAD_HI = 1;
  localparam int KEY_COMMIT  = 2;
  localparam int KEY_CLEAR   = 3;

  typedef enum logic [2:0] {
    EMPTY,
    LO_ONLY,
    HI_ONLY,
    FULL,
    SEND
  } loader_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes and debounces one active-low push-button.
// Emits a single-cycle pulse when the debounced level falls (press).
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_prevStable;
  logic [CNT_W-1:0] r_count;

  // The stable level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_stable     <= 1'b1;
      r_prevStable <= 1'b1;
      r_count      <= '0;
    end else begin
      r_sync1      <= raw_n;
      r_sync2      <= r_sync1;
      r_prevStable <= r_stable;
      if (r_sync2 == r_stable) begin
        r_count <= '0;
      end else if (r_count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_count  <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign press_pulse = r_prevStable & ~r_stable;

endmodule

// File: rtl/key_operand_loader.sv
// Builds a Q16.16 operand from the switches in two halves using debounced
// keys, then offers it to the neural datapath over valid/ready.
module key_operand_loader
  import neural_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DATA_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key,
  input  logic [15:0]       sw,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] operand,
  output logic              lo_loaded,
  output logic              hi_loaded,
  output logic              err,
  output logic [7:0]        sent_count
);

  logic [3:0]        w_press;
  logic [15:0]       r_swMeta;
  logic [15:0]       r_swSync;
  loader_state_t     r_state;
  loader_state_t     w_stateNext;
  logic [DATA_W-1:0] r_operand;
  logic [DATA_W-1:0] w_operandNext;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_dataNext;
  logic              r_valid;
  logic              w_validNext;
  logic              r_lo;
  logic              w_loNext;
  logic              r_hi;
  logic              w_hiNext;
  logic              r_err;
  logic              w_errNext;
  logic [7:0]        r_count;
  logic [7:0]        w_countNext;

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .raw_n      (key[g]),
      .press_pulse(w_press[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_swMeta  <= '0;
      r_swSync  <= '0;
      r_state   <= EMPTY;
      r_operand <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_lo      <= 1'b0;
      r_hi      <= 1'b0;
      r_err     <= 1'b0;
      r_count   <= '0;
    end else begin
      r_swMeta  <= sw;
      r_swSync  <= r_swMeta;
      r_state   <= w_stateNext;
      r_operand <= w_operandNext;
      r_data    <= w_dataNext;
      r_valid   <= w_validNext;
      r_lo      <= w_loNext;
      r_hi      <= w_hiNext;
      r_err     <= w_errNext;
      r_count   <= w_countNext;
    end
  end

  // Only the highest-priority event acts; everything is dropped while sending.
  always_comb begin
    w_stateNext   = r_state;
    w_operandNext = r_operand;
    w_dataNext    = r_data;
    w_validNext   = r_valid;
    w_loNext      = r_lo;
    w_hiNext      = r_hi;
    w_errNext     = r_err;
    w_countNext   = r_count;
    case (r_state)
      SEND: begin
        if (out_ready) begin
          w_validNext = 1'b0;
          w_countNext = r_count + 8'd1;
          w_stateNext = FULL;
        end
      end
      default: begin
        if (w_press[KEY_CLEAR]) begin
          w_operandNext = '0;
          w_loNext      = 1'b0;
          w_hiNext      = 1'b0;
          w_errNext     = 1'b0;
          w_stateNext   = EMPTY;
        end else if (w_press[KEY_COMMIT]) begin
          if (r_state == FULL) begin
            w_dataNext  = r_operand;
            w_validNext = 1'b1;
            w_stateNext = SEND;
          end else begin
            w_errNext = 1'b1;
          end
        end else if (w_press[KEY_LOAD_HI]) begin
          w_operandNext[DATA_W-1:HALF_W] = r_swSync;
          w_hiNext = 1'b1;
          if (r_state == EMPTY) begin
            w_stateNext = HI_ONLY;
          end else if (r_state == LO_ONLY) begin
            w_stateNext = FULL;
          end
        end else if (w_press[KEY_LOAD_LO]) begin
          w_operandNext[HALF_W-1:0] = r_swSync;
          w_loNext = 1'b1;
          if (r_state == EMPTY) begin
            w_stateNext = LO_ONLY;
          end else if (r_state == HI_ONLY) begin
            w_stateNext = FULL;
          end
        end
      end
    endcase
  end

  assign out_data   = r_data;
  assign out_valid  = r_valid;
  assign operand    = r_operand;
  assign lo_loaded  = r_lo;
  assign hi_loaded  = r_hi;
  assign err        = r_err;
  assign sent_count = r_count;

endmodule

// File: tb/tb_key_operand_loader.sv
// Self-checking bench for key_operand_loader using a flag-based model of
// the operand loader and directed plus randomized key/switch sequences.
module tb_key_operand_loader;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key = 4'hF;
  logic [15:0] sw = '0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic [31:0] operand;
  logic        lo_loaded;
  logic        hi_loaded;
  logic        err;
  logic [7:0]  sent_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] mOperand;
  logic [31:0] mData;
  logic        mLo;
  logic        mHi;
  logic        mErr;
  logic        mValid;
  int          mCount;

  key_operand_loader #(.DEBOUNCE_CYCLES(N), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .sw        (sw),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .operand   (operand),
    .lo_loaded (lo_loaded),
    .hi_loaded (hi_loaded),
    .err       (err),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".operand"}, operand, mOperand);
    checkVal({tag, ".lo_loaded"}, {31'd0, lo_loaded}, {31'd0, mLo});
    checkVal({tag, ".hi_loaded"}, {31'd0, hi_loaded}, {31'd0, mHi});
    checkVal({tag, ".err"}, {31'd0, err}, {31'd0, mErr});
    checkVal({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, mValid});
    checkVal({tag, ".out_data"}, out_data, mData);
    checkVal({tag, ".sent_count"}, {24'd0, sent_count}, 32'(mCount % 256));
  endtask

  task automatic modelReset();
    mOperand = '0; mData = '0; mLo = 0; mHi = 0; mErr = 0; mValid = 0; mCount = 0;
  endtask

  // Behavioural rules: offered operand locks out keys; priority clear>commit>hi>lo.
  task automatic modelEvents(input logic [3:0] mask, input logic [15:0] v);
    if (mValid) return;
    if (mask[3]) begin
      mOperand = '0; mLo = 0; mHi = 0; mErr = 0;
    end else if (mask[2]) begin
      if (mLo && mHi) begin
        mData = mOperand; mValid = 1;
      end else begin
        mErr = 1;
      end
    end else if (mask[1]) begin
      mOperand[31:16] = v; mHi = 1;
    end else if (mask[0]) begin
      mOperand[15:0] = v; mLo = 1;
    end
  endtask

  // A clean press: held well past the debounce window, then fully released.
  task automatic applyStimulus(input logic [3:0] mask, input logic [15:0] v, input string tag);
    @(negedge clk);
    sw = v;
    key = ~mask;
    repeat (10) @(negedge clk);
    key = 4'hF;
    repeat (10) @(negedge clk);
    modelEvents(mask, v);
    checkOutput(tag);
  endtask

  task automatic handshake(input int stall, input string tag);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      checkVal({tag, ".stall_valid"}, {31'd0, out_valid}, {31'd0, mValid});
      checkVal({tag, ".stall_data"}, out_data, mData);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (mValid) begin
      mValid = 0;
      mCount++;
    end
    checkOutput(tag);
  endtask

  initial begin
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset");
    rst = 1'b0;
    @(negedge clk);

    // Bounce shorter than the window, then a real press landing at edge N+3.
    sw = 16'h8000;
    key = 4'b1110;
    repeat (3) @(negedge clk);
    key = 4'hF;
    repeat (2) @(negedge clk);
    key = 4'b1110;
    repeat (N + 2) @(posedge clk);
    #1;
    checkOutput("glitch_pre");
    @(posedge clk); #1;
    modelEvents(4'b0001, 16'h8000);
    checkOutput("glitch_edge");
    repeat (5) @(negedge clk);
    key = 4'hF;
    repeat (10) @(negedge clk);
    checkOutput("glitch_single");

    applyStimulus(4'b1000, 16'h0000, "clr0");
    applyStimulus(4'b0010, 16'h0001, "load_hi");
    applyStimulus(4'b0001, 16'h4000, "load_lo");
    applyStimulus(4'b0100, 16'h0000, "commit");
    checkVal("commit.data", out_data, 32'h0001_4000);
    handshake(5, "send1");
    checkVal("send1.count", {24'd0, sent_count}, 32'd1);

    applyStimulus(4'b1000, 16'h0000, "clr1");
    applyStimulus(4'b0001, 16'h1234, "inc_lo");
    applyStimulus(4'b0100, 16'h0000, "inc_commit");
    checkVal("inc_commit.err", {31'd0, err}, 32'd1);
    applyStimulus(4'b1000, 16'h0000, "inc_clear");
    checkVal("inc_clear.operand", operand, 32'd0);

    applyStimulus(4'b0010, 16'h1111, "sim_hi");
    applyStimulus(4'b0001, 16'h2222, "sim_lo");
    applyStimulus(4'b1100, 16'h0000, "sim_clr_commit");
    applyStimulus(4'b0011, 16'hABCD, "sim_hi_lo");
    checkVal("sim_hi_lo.operand", operand, 32'hABCD_0000);

    applyStimulus(4'b0001, 16'h5555, "lock_lo");
    applyStimulus(4'b0100, 16'h0000, "lock_commit");
    applyStimulus(4'b1000, 16'h0000, "lock_clear");
    applyStimulus(4'b0001, 16'h9999, "lock_load");
    handshake(2, "lock_send");
    repeat (12) @(negedge clk);
    checkOutput("lock_after");

    for (int i = 0; i < 40; i++) begin
      applyStimulus(4'($urandom_range(1, 15)), 16'($urandom), "rand");
      if (mValid && ($urandom_range(0, 1) == 1)) begin
        handshake(int'($urandom_range(0, 4)), "rand_hs");
      end
    end
    if (mValid) handshake(1, "rand_final");

    // Asynchronous reset in the middle of an offer.
    applyStimulus(4'b0010, 16'h0F0F, "rst_hi");
    applyStimulus(4'b0001, 16'hF0F0, "rst_lo");
    applyStimulus(4'b0100, 16'h0000, "rst_commit");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async_reset");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(4'b0010, 16'h0002, "wrap_hi");
    applyStimulus(4'b0001, 16'h0003, "wrap_lo");
    for (int i = 0; i < 256; i++) begin
      applyStimulus(4'b0100, 16'h0000, "wrap_commit");
      handshake(0, "wrap_hs");
    end
    checkVal("wrap.count", {24'd0, sent_count}, 32'd0);
    checkVal("wrap.operand", operand, 32'h0002_0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_operand_loader.md
Name: key_operand_loader

Overview:
- Input-side counterpart to the hex-display output path on the DE2 board.
- Debounces the four active-low push-buttons and assembles a 32-bit Q16.16 operand from SW[15:0] in two halves.
- Hands the operand to the downstream neural datapath (sigmoid/neuron) over a valid/ready handshake.
- Exposes the operand and status so the board top can drive the seven-segment displays and LEDs.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz); minimum 2.
- DATA_W, 32, operand width; must equal 2*16.

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  asynchronous active-high reset
- key  in  4  raw push-buttons, active-low; [0]=load low, [1]=load high, [2]=commit, [3]=clear
- sw  in  16  raw switches, operand half source
- out_data  out  32  operand to datapath
- out_valid  out  1  operand offered
- out_ready  in  1  datapath accepts
- operand  out  32  current operand register, for display
- lo_loaded  out  1  low half written since last clear
- hi_loaded  out  1  high half written since last clear
- err  out  1  sticky: commit attempted while incomplete
- sent_count  out  8  number of completed handshakes, wraps

Behaviour:
- Reset (async assert, sync release):
  - operand=0, out_valid=0, lo_loaded=0, hi_loaded=0, err=0, sent_count=0, state=EMPTY.
  - Debouncer stable levels = 1 (released); counters = 0.
- key and sw each pass through a 2-flop synchronizer.
- Debounce, per key:
  - Counter clears whenever the synced level equals the stable level; otherwise it increments.
  - On the DEBOUNCE_CYCLES-th consecutive mismatched cycle, stable takes the synced value and the counter clears.
  - A press event is a one-cycle pulse while stable has just fallen 1->0 (registered previous-stable & ~stable). Releases generate no event.
- Latency: with edge 1 as the first edge sampling key low, operand/flags update at edge DEBOUNCE_CYCLES+3.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no event. A held key produces exactly one event.
- Simultaneous events in one cycle: only the highest priority acts, order clear > commit > load high > load low. The others are discarded.
- States: EMPTY, LO_ONLY, HI_ONLY, FULL, SEND.
- Load low: operand[15:0] <= synced sw; lo_loaded <= 1.
  - EMPTY->LO_ONLY, HI_ONLY->FULL; LO_ONLY and FULL stay (overwrite).
- Load high: operand[31:16] <= synced sw; hi_loaded <= 1.
  - EMPTY->HI_ONLY, LO_ONLY->FULL; HI_ONLY and FULL stay (overwrite).
- Commit:
  - In FULL: out_data <= operand, out_valid <= 1, go to SEND.
  - In EMPTY, LO_ONLY or HI_ONLY: err <= 1, state unchanged.
- Clear, in any state other than SEND: operand, lo_loaded, hi_loaded and err <= 0, go to EMPTY. sent_count is not cleared.
- SEND:
  - out_valid and out_data are held stable until out_ready is sampled high.
  - On that edge: out_valid <= 0, sent_count <= sent_count+1 (wraps 255->0), return to FULL with operand retained.
  - All key events during SEND (including clear) are ignored and dropped, not queued.
- out_valid never asserts combinationally from out_ready. The earliest re-offer is via a new commit event after returning to FULL.
- Reset mid-SEND: out_valid drops immediately (async). No handshake is counted.

Decomposition:
- Shared package neural_io_pkg:
  - state enum loader_state_t {EMPTY, LO_ONLY, HI_ONLY, FULL, SEND}
  - key index constants KEY_LOAD_LO=0, KEY_LOAD_HI=1, KEY_COMMIT=2, KEY_CLEAR=3
  - OPERAND_W=32, HALF_W=16
- Sub-module key_debouncer (parameter DEBOUNCE_CYCLES; ports clk, rst, raw_n, press_pulse), instantiated four times via generate. It includes its own 2-flop synchronizer.

Test Plan (DEBOUNCE_CYCLES=4):
- Glitch/bounce: key[0] low for 3 cycles, high 2 cycles, then low 10 cycles with sw=16'h8000 -> exactly one load event at the specified edge. operand=32'h0000_8000, lo_loaded=1, state LO_ONLY.
- Full load and send: sw=16'h0001 press key[1], sw=16'h4000 press key[0], press key[2], out_ready held 0 for 5 cycles then 1 -> out_data=32'h0001_4000. out_valid stays 1 through the stall and drops the edge after ready. sent_count=1, state FULL.
- Incomplete commit: only key[0] loaded, press key[2] -> err=1, out_valid stays 0. Then press key[3] -> err=0, operand=0, state EMPTY.
- Simultaneous: key[3] and key[2] events in the same cycle while FULL -> clear wins, out_valid stays 0. key[1] and key[0] together with sw=16'hABCD -> only operand[31:16]=16'hABCD written.
- SEND lockout and wrap: press key[3] and key[0] during SEND -> operand unchanged, no action after the handshake. Perform 256 handshakes -> sent_count wraps to 0.
- Async reset while out_valid=1: assert rst mid-cycle -> out_valid=0 and all outputs at reset values before the next clk edge.
